uart_transmitter: RTL and testbench

Serial transmit stage that consumes the 16× oversampling strobe produced by `baud_controller` and serialises one byte per write as an 11-bit frame: start, 8 data LSB-first, even parity, stop. It sits between the host write interface and the `TxD` line. It is the direct downstream consumer of `sample_ENABLE`, and the future `uart_receiver` is its loopback partner.

---
 rtl/uart_pkg.sv | 55 +++++
 rtl/baud_controller.sv | 50 +++++
 rtl/uart_transmitter.sv | 187 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry and the
// baud-code to strobe-divisor mapping used by the baud controller.
package uart_pkg;

    localparam int FRAME_BITS = 11;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = FRAME_BITS - 3;
    localparam int DIV_W      = 20;

    localparam logic [2:0] DEFAULT_BAUD_SEL = 3'b111;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_ARM    = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
        TX_PARITY = 3'd4,
        TX_STOP   = 3'd5
    } tx_state_t;

    function automatic longint unsigned baud_rate(input logic [2:0] sel);
        longint unsigned rate;
        case (sel)
            3'd0:    rate = 64'd300;
            3'd1:    rate = 64'd1200;
            3'd2:    rate = 64'd4800;
            3'd3:    rate = 64'd9600;
            3'd4:    rate = 64'd19200;
            3'd5:    rate = 64'd38400;
            3'd6:    rate = 64'd57600;
            default: rate = 64'd115200;
        endcase
        return rate;
    endfunction

    // Rounded CLK_HZ / (16 * baud); a divisor of 0 would stall the strobe, so clamp to 1.
    function automatic logic [DIV_W-1:0] baud_divisor(input longint unsigned clk_hz,
                                                      input logic [2:0]      sel);
        longint unsigned rate;
        longint unsigned div;
        rate = baud_rate(sel);
        div  = (clk_hz + 64'd8 * rate) / (64'd16 * rate);
        if (div == 64'd0) begin
            div = 64'd1;
        end else begin
            div = div;
        end
        return div[DIV_W-1:0];
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/baud_controller.sv
// Free-running 16x oversampling strobe generator. The divisor comes from a
// constant table, so the rate code only selects among eight elaborated values.
module baud_controller
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    localparam logic [DIV_W-1:0] DIV_TABLE [0:7] = '{
        baud_divisor(64'(CLK_HZ), 3'd0),
        baud_divisor(64'(CLK_HZ), 3'd1),
        baud_divisor(64'(CLK_HZ), 3'd2),
        baud_divisor(64'(CLK_HZ), 3'd3),
        baud_divisor(64'(CLK_HZ), 3'd4),
        baud_divisor(64'(CLK_HZ), 3'd5),
        baud_divisor(64'(CLK_HZ), 3'd6),
        baud_divisor(64'(CLK_HZ), 3'd7)
    };

    logic [DIV_W-1:0] r_count;
    logic             r_strobe;
    logic [DIV_W-1:0] w_div;
    logic             w_wrap;

    assign w_div  = DIV_TABLE[baud_select];
    // >= rather than == so a switch to a shorter divisor cannot strand the count.
    assign w_wrap = (r_count >= (w_div - DIV_W'(1)));

    // Divider counter and registered strobe: one pulse every w_div cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_strobe <= 1'b0;
        end else if (w_wrap) begin
            r_count  <= '0;
            r_strobe <= 1'b1;
        end else begin
            r_count  <= r_count + DIV_W'(1);
            r_strobe <= 1'b0;
        end
    end

    assign sample_ENABLE = r_strobe;

endmodule

// File: rtl/uart_transmitter.sv
// 8E1 UART transmitter: start, 8 data bits LSB-first, even parity, stop, with
// each bit held for 16 strobes of the baud controller running at the latched rate.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    input  logic [2:0] baud_select,
    output logic       TxD,
    output logic       Tx_BUSY
);

    localparam int                TICK_W    = $clog2(OVERSAMPLE);
    localparam int                BIT_W     = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t         r_state;
    logic [TICK_W-1:0] r_tick;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [7:0]        r_data;
    logic [2:0]        r_baud_sel;
    logic              r_txd;
    logic              r_busy;

    tx_state_t         w_state_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic              w_load;
    logic              w_txd_nxt;
    logic              w_strobe;
    logic              w_bit_done;
    logic              w_abort;

    baud_controller #(
        .CLK_HZ (CLK_HZ)
    ) u_baud (
        .clk           (clk),
        .reset         (reset),
        .baud_select   (r_baud_sel),
        .sample_ENABLE (w_strobe)
    );

    assign w_bit_done = w_strobe && (r_tick == TICK_LAST);
    assign w_abort    = !Tx_EN && (r_state != TX_IDLE);

    // Next-state, counter and serial-line decode; outputs are derived from the
    // next state so TxD and Tx_BUSY can be registered without an extra cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit_idx;
        w_load      = 1'b0;
        w_txd_nxt   = 1'b1;

        if (w_abort) begin
            w_state_nxt = TX_IDLE;
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (Tx_WR && Tx_EN) begin
                        w_state_nxt = TX_ARM;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = TX_IDLE;
                    end
                end
                TX_ARM: begin
                    w_tick_nxt = '0;
                    if (w_strobe) begin
                        w_state_nxt = TX_START;
                    end else begin
                        w_state_nxt = TX_ARM;
                    end
                end
                TX_START: begin
                    if (w_strobe) begin
                        w_tick_nxt = r_tick + TICK_W'(1);
                    end else begin
                        w_tick_nxt = r_tick;
                    end
                    if (w_bit_done) begin
                        w_state_nxt = TX_DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = TX_START;
                    end
                end
                TX_DATA: begin
                    if (w_strobe) begin
                        w_tick_nxt = r_tick + TICK_W'(1);
                    end else begin
                        w_tick_nxt = r_tick;
                    end
                    if (w_bit_done && (r_bit_idx == BIT_LAST)) begin
                        w_state_nxt = TX_PARITY;
                        w_bit_nxt   = '0;
                    end else if (w_bit_done) begin
                        w_state_nxt = TX_DATA;
                        w_bit_nxt   = r_bit_idx + BIT_W'(1);
                    end else begin
                        w_state_nxt = TX_DATA;
                    end
                end
                TX_PARITY: begin
                    if (w_strobe) begin
                        w_tick_nxt = r_tick + TICK_W'(1);
                    end else begin
                        w_tick_nxt = r_tick;
                    end
                    if (w_bit_done) begin
                        w_state_nxt = TX_STOP;
                    end else begin
                        w_state_nxt = TX_PARITY;
                    end
                end
                TX_STOP: begin
                    if (w_strobe) begin
                        w_tick_nxt = r_tick + TICK_W'(1);
                    end else begin
                        w_tick_nxt = r_tick;
                    end
                    if (w_bit_done) begin
                        w_state_nxt = TX_IDLE;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = TX_STOP;
                    end
                end
                default: begin
                    w_state_nxt = TX_IDLE;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            endcase
        end

        case (w_state_nxt)
            TX_START:  w_txd_nxt = 1'b0;
            TX_DATA:   w_txd_nxt = r_data[w_bit_nxt];
            TX_PARITY: w_txd_nxt = even_parity(r_data);
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    // FSM state, bit counters and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= TX_IDLE;
            r_tick    <= '0;
            r_bit_idx <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_idx <= w_bit_nxt;
            r_txd     <= w_txd_nxt;
            r_busy    <= (w_state_nxt != TX_IDLE);
        end
    end

    // Frame payload and rate are captured only on an accepted write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= 8'h00;
            r_baud_sel <= DEFAULT_BAUD_SEL;
        end else if (w_load) begin
            r_data     <= Tx_DATA;
            r_baud_sel <= baud_select;
        end else begin
            r_data     <= r_data;
            r_baud_sel <= r_baud_sel;
        end
    end

    assign TxD     = r_txd;
    assign Tx_BUSY = r_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frames are predicted from the byte
// and the nominal baud rate, then compared cycle by cycle on the serial line.
module tb_uart_transmitter;

    localparam int CLK_HZ = 50_000_000;

    logic       clk = 1'b0;
    logic       reset;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic [2:0] baud_select;
    logic       TxD;
    logic       Tx_BUSY;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CLK_HZ(CLK_HZ)) dut (
        .clk         (clk),
        .reset       (reset),
        .Tx_EN       (Tx_EN),
        .Tx_WR       (Tx_WR),
        .Tx_DATA     (Tx_DATA),
        .baud_select (baud_select),
        .TxD         (TxD),
        .Tx_BUSY     (Tx_BUSY)
    );

    // Strobe period in clock cycles: nearest integer to CLK_HZ / (16 * baud).
    function automatic int period_of(input logic [2:0] code);
        int baud;
        case (code)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        return $rtoi(CLK_HZ / (16.0 * baud) + 0.5);
    endfunction

    // Line levels in transmission order: start, d0..d7, even parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 1);
        f[10] = 1'b1;
        return f;
    endfunction

    // Sends one byte and checks latency, every bit's level over its full length,
    // and the busy window. poke_kind 1 writes 0xFF at poke_bit, 2 switches the rate to 111.
    task automatic run_frame(input logic [7:0] d, input logic [2:0] code,
                             input int poke_bit, input int poke_kind);
        int          p;
        int          k;
        logic [10:0] fr;
        bit          txd_bad;
        bit          busy_bad;
        logic        txd_seen;
        logic        busy_seen;
        p  = period_of(code);
        fr = frame_of(d);
        repeat ($urandom_range(1, 40)) @(negedge clk);
        Tx_DATA = d; baud_select = code; Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0; Tx_DATA = 8'($urandom); baud_select = 3'($urandom);
        checks++;
        if (Tx_BUSY !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_accept data=%02h: Tx_BUSY=%b expected 1", d, Tx_BUSY);
        end
        k = 1;
        while (TxD !== 1'b0 && k <= p + 1) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (TxD !== 1'b0 || k < 2 || k > p + 1) begin
            failures++;
            $display("FAIL start_latency data=%02h: TxD=%b after %0d cycles, expected fall within 2..%0d",
                     d, TxD, k, p + 1);
            return;
        end
        for (int b = 0; b < 11; b++) begin
            txd_bad = 1'b0; busy_bad = 1'b0; txd_seen = fr[b]; busy_seen = 1'b1;
            for (int c = 0; c < 16 * p; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (b == poke_bit && c == 0 && poke_kind == 1) begin
                    Tx_WR = 1'b1; Tx_DATA = 8'hFF;
                end
                if (b == poke_bit && c == 0 && poke_kind == 2) baud_select = 3'b111;
                if (b == poke_bit && c == 1 && poke_kind == 1) Tx_WR = 1'b0;
                if (TxD !== fr[b] && !txd_bad) begin txd_bad = 1'b1; txd_seen = TxD; end
                if (Tx_BUSY !== 1'b1 && !busy_bad) begin busy_bad = 1'b1; busy_seen = Tx_BUSY; end
            end
            checks++;
            if (txd_bad) begin
                failures++;
                $display("FAIL frame_bit%0d data=%02h code=%0d: TxD=%b expected %b for all %0d cycles",
                         b, d, code, txd_seen, fr[b], 16 * p);
            end
            checks++;
            if (busy_bad) begin
                failures++;
                $display("FAIL busy_during_bit%0d data=%02h: Tx_BUSY=%b expected 1", b, d, busy_seen);
            end
        end
        @(negedge clk);
        checks++;
        if (Tx_BUSY !== 1'b0 || TxD !== 1'b1) begin
            failures++;
            $display("FAIL frame_end data=%02h: Tx_BUSY=%b TxD=%b expected 0 and 1", d, Tx_BUSY, TxD);
        end
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1; Tx_EN = 1'b0; Tx_WR = 1'b0; Tx_DATA = 8'h00; baud_select = 3'b111;
        repeat (3) @(negedge clk);
        checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: TxD=%b Tx_BUSY=%b expected 1 and 0", TxD, Tx_BUSY);
        end
        reset = 1'b0; Tx_EN = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL idle_after_reset: TxD=%b Tx_BUSY=%b expected 1 and 0 throughout", TxD, Tx_BUSY);
        end
    endtask

    task automatic test_basic();
        run_frame(8'hA5, 3'b111, -1, 0);
    endtask

    task automatic test_odd_ones();
        run_frame(8'h07, 3'b111, -1, 0);
        run_frame(8'h00, 3'b111, -1, 0);
    endtask

    task automatic test_write_while_busy();
        bit bad;
        run_frame(8'hA5, 3'b111, 3, 1);
        bad = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL no_second_frame: TxD=%b Tx_BUSY=%b expected line idle 1 and 0", TxD, Tx_BUSY);
        end
    endtask

    task automatic test_enable_drop();
        int         p;
        int         k;
        logic [7:0] d;
        bit         bad;
        p = period_of(3'b111);
        d = 8'($urandom);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        Tx_DATA = d; baud_select = 3'b111; Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        k = 1;
        while (TxD !== 1'b0 && k <= p + 1) begin @(negedge clk); k++; end
        checks++;
        if (TxD !== 1'b0) begin
            failures++;
            $display("FAIL drop_start: TxD=%b expected 0 within %0d cycles", TxD, p + 1);
            return;
        end
        repeat (72 * p) @(negedge clk);
        checks++;
        if (TxD !== d[3]) begin
            failures++;
            $display("FAIL drop_in_bit3 data=%02h: TxD=%b expected %b", d, TxD, d[3]);
        end
        Tx_EN = 1'b0;
        @(negedge clk);
        checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL drop_abort: TxD=%b Tx_BUSY=%b expected 1 and 0", TxD, Tx_BUSY);
        end
        Tx_WR = 1'b1; Tx_DATA = 8'($urandom);
        @(negedge clk);
        Tx_WR = 1'b0;
        bad = 1'b0;
        repeat (50) begin
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL write_while_disabled: TxD=%b Tx_BUSY=%b expected 1 and 0", TxD, Tx_BUSY);
        end
        Tx_EN = 1'b1;
        run_frame(8'($urandom), 3'b111, -1, 0);
    endtask

    task automatic test_reset_mid_frame();
        int         p;
        int         k;
        logic [7:0] d;
        bit         bad;
        p = period_of(3'b111);
        d = 8'($urandom);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        Tx_DATA = d; baud_select = 3'b111; Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        k = 1;
        while (TxD !== 1'b0 && k <= p + 1) begin @(negedge clk); k++; end
        checks++;
        if (TxD !== 1'b0) begin
            failures++;
            $display("FAIL reset_start: TxD=%b expected 0 within %0d cycles", TxD, p + 1);
            return;
        end
        repeat (144 * p + 20) @(negedge clk);
        checks++;
        if (TxD !== (($countones(d) % 2) == 1)) begin
            failures++;
            $display("FAIL reset_in_parity data=%02h: TxD=%b expected parity %0d", d, TxD, $countones(d) % 2);
        end
        reset = 1'b1; Tx_WR = 1'b1; Tx_DATA = 8'h5A;
        @(negedge clk);
        checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: TxD=%b Tx_BUSY=%b expected 1 and 0", TxD, Tx_BUSY);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0; Tx_WR = 1'b0;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL write_during_reset: TxD=%b Tx_BUSY=%b expected 1 and 0", TxD, Tx_BUSY);
        end
    endtask

    task automatic test_rate_latch();
        run_frame(8'($urandom), 3'b011, 2, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_ones();
        test_write_while_busy();
        test_enable_drop();
        test_reset_mid_frame();
        test_rate_latch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
